// File: rtl/prbs15_pkg.sv
// Shared definitions for the 15-bit PRBS word checker and its scrambler model.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package prbs15_pkg;

   localparam int PRBS_W = 15;

   // Checker FSM. The encoding is visible on the debug port, so it is fixed.
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // One word step of the x^15 + x^14 + 1 sequence: shift left, feed back b14^b13.
   function automatic logic [PRBS_W-1:0] prbs15_next(input logic [PRBS_W-1:0] w);
      return {w[PRBS_W-2:0], w[PRBS_W-1] ^ w[PRBS_W-2]};
   endfunction

endpackage

// File: rtl/prbs15_word_checker.sv
// Locks onto a PRBS15 word stream, then counts mismatched words with a saturating counter.
// Latency: err_pulse/err_cnt/locked/state_o all update on the edge that registers the word.
// Backpressure: none; idle cycles (din_valid=0) freeze the checker and are never stalled.
module prbs15_word_checker
   import prbs15_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic [PRBS_W-1:0]    din,
   input  logic                 err_clr,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [1:0]           state_o
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int NW = $clog2(UNLOCK_CNT + 1);

   // Last match/miss before a transition; counters compare against these.
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
   localparam logic [NW-1:0] MISS_LAST  = NW'(UNLOCK_CNT - 1);

   state_t                 state_q, state_d;
   logic [PRBS_W-1:0]      expected_q, expected_d;
   logic [MW-1:0]          match_q, match_d;
   logic [NW-1:0]          miss_q, miss_d;
   logic [ERR_CNT_W-1:0]   err_q, err_d;
   logic                   pulse_q, pulse_d;
   logic                   locked_q, locked_d;

   logic                   hit;
   logic                   zero_word;

   assign hit       = (din == expected_q);
   assign zero_word = (din == '0);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; only valid words move the FSM.
   always_comb begin
      state_d = state_q;
      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               // The all-zero word is the LFSR lock-up state and cannot seed a prediction.
               if (!zero_word) begin
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (hit) begin
                  if (match_q == MATCH_LAST) begin
                     state_d = LOCKED;
                  end
               end else if (zero_word) begin
                  state_d = SEARCH;
               end
            end
            LOCKED: begin
               if (!hit && (miss_q == MISS_LAST)) begin
                  state_d = SEARCH;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   // Predictor, counters and output strobes for the next cycle.
   always_comb begin
      expected_d = expected_q;
      match_d    = match_q;
      miss_d     = miss_q;
      err_d      = err_q;
      pulse_d    = 1'b0;
      locked_d   = (state_d == LOCKED);

      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               if (!zero_word) begin
                  expected_d = prbs15_next(din);
                  match_d    = '0;
               end
            end
            VERIFY: begin
               if (hit) begin
                  expected_d = prbs15_next(expected_q);
                  match_d    = match_q + 1'b1;
                  if (match_q == MATCH_LAST) begin
                     miss_d = '0;
                  end
               end else if (!zero_word) begin
                  // Reseed from the received word rather than falling back to SEARCH.
                  expected_d = prbs15_next(din);
                  match_d    = '0;
               end
            end
            LOCKED: begin
               // Free-running predictor: a single flipped bit costs exactly one error.
               expected_d = prbs15_next(expected_q);
               if (hit) begin
                  miss_d = '0;
               end else begin
                  pulse_d = 1'b1;
                  miss_d  = miss_q + 1'b1;
                  if (err_q != '1) begin
                     err_d = err_q + 1'b1;
                  end
               end
            end
            default: begin
               expected_d = expected_q;
            end
         endcase
      end

      // Clear has priority over a simultaneous increment; the strobe is unaffected.
      if (err_clr) begin
         err_d = '0;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         expected_q <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         err_q      <= '0;
         pulse_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         expected_q <= expected_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
         pulse_q    <= pulse_d;
         locked_q   <= locked_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = pulse_q;
   assign err_cnt   = err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_prbs15_word_checker.sv
// Directed bench with a behavioural scoreboard for prbs15_word_checker.
// Two instances share stimulus: default 16-bit counter and a 4-bit counter for saturation.
// Each driven word pushes its expected outputs; they are popped and compared after the edge.
module tb_prbs15_word_checker;
   import prbs15_pkg::*;

   localparam int TB_LOCK   = 4;
   localparam int TB_UNLOCK = 3;

   logic        clk;
   logic        rst;
   logic        din_valid;
   logic [14:0] din;
   logic        err_clr;

   logic        locked_a, pulse_a;
   logic [15:0] cnt_a;
   logic [1:0]  st_a;
   logic        locked_b, pulse_b;
   logic [3:0]  cnt_b;
   logic [1:0]  st_b;

   prbs15_word_checker #(.LOCK_CNT(TB_LOCK), .UNLOCK_CNT(TB_UNLOCK), .ERR_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .err_clr(err_clr),
      .locked(locked_a), .err_pulse(pulse_a), .err_cnt(cnt_a), .state_o(st_a)
   );

   prbs15_word_checker #(.LOCK_CNT(TB_LOCK), .UNLOCK_CNT(TB_UNLOCK), .ERR_CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .err_clr(err_clr),
      .locked(locked_b), .err_pulse(pulse_b), .err_cnt(cnt_b), .state_o(st_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        lk;
      logic        pl;
      logic [15:0] c16;
      logic [3:0]  c4;
      logic [1:0]  st;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int          m_state;
   logic [14:0] m_exp;
   int          m_match;
   int          m_miss;
   int          m_err16;
   int          m_err4;
   logic        m_pulse;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_exp = '0; m_match = 0; m_miss = 0;
      m_err16 = 0; m_err4 = 0; m_pulse = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [14:0] d, input logic c);
      m_pulse = 1'b0;
      if (v) begin
         case (m_state)
            0: if (d != 15'd0) begin
                  m_exp = prbs15_next(d); m_match = 0; m_state = 1;
               end
            1: if (d == m_exp) begin
                  m_exp = prbs15_next(m_exp);
                  m_match++;
                  if (m_match == TB_LOCK) begin m_state = 2; m_miss = 0; end
               end else if (d != 15'd0) begin
                  m_exp = prbs15_next(d); m_match = 0;
               end else begin
                  m_state = 0;
               end
            default: begin
               if (d == m_exp) begin
                  m_miss = 0;
               end else begin
                  m_pulse = 1'b1;
                  m_miss++;
                  if (m_err16 < 65535) m_err16++;
                  if (m_err4 < 15) m_err4++;
                  if (m_miss == TB_UNLOCK) m_state = 0;
               end
               m_exp = prbs15_next(m_exp);
            end
         endcase
      end
      if (c) begin m_err16 = 0; m_err4 = 0; end
   endtask

   task automatic step(input logic v, input logic [14:0] d, input logic c);
      exp_t e;
      exp_t g;
      @(negedge clk);
      din_valid = v; din = d; err_clr = c;
      model_step(v, d, c);
      e.lk = (m_state == 2); e.pl = m_pulse;
      e.c16 = 16'(m_err16); e.c4 = 4'(m_err4); e.st = 2'(m_state);
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk("sb_depth", 16'(sb.size()), 16'd1);
      if (sb.size() != 0) begin
         g = sb.pop_front();
         chk("locked",    16'(locked_a), 16'(g.lk));
         chk("err_pulse", 16'(pulse_a),  16'(g.pl));
         chk("err_cnt",   cnt_a,         g.c16);
         chk("state_o",   16'(st_a),     16'(g.st));
         chk("err_cnt4",  16'(cnt_b),    16'(g.c4));
         chk("locked4",   16'(locked_b), 16'(g.lk));
      end
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) step(1'b1, m_exp, 1'b0);
   endtask

   task automatic bad(input logic c);
      step(1'b1, m_exp ^ 15'h0008, c);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_locked"}, 16'(locked_a), 16'd0);
      chk({tag, "_pulse"},  16'(pulse_a),  16'd0);
      chk({tag, "_cnt"},    cnt_a,         16'd0);
      chk({tag, "_state"},  16'(st_a),     16'd0);
      chk({tag, "_cnt4"},   16'(cnt_b),    16'd0);
      chk({tag, "_state4"}, 16'(st_b),     16'd0);
   endtask

   initial begin
      rst = 1'b0; din_valid = 1'b0; din = '0; err_clr = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: acquire lock on a walking-one seed.
      step(1'b1, 15'h0001, 1'b0);
      chk("t1_verify", 16'(st_a), 16'd1);
      step(1'b1, 15'h0002, 1'b0);
      step(1'b1, 15'h0004, 1'b0);
      step(1'b1, 15'h0008, 1'b0);
      step(1'b1, 15'h0010, 1'b0);
      step(1'b1, 15'h0020, 1'b0);
      chk("t1_locked", 16'(locked_a), 16'd1);
      chk("t1_errcnt", cnt_a, 16'd0);

      // 2: a single flipped bit is one error, lock is kept.
      good(3);
      bad(1'b0);
      chk("t2_pulse", 16'(pulse_a), 16'd1);
      chk("t2_cnt", cnt_a, 16'd1);
      good(1);
      chk("t2_nopulse", 16'(pulse_a), 16'd0);
      chk("t2_locked", 16'(locked_a), 16'd1);

      // 3: three consecutive bad words drop lock; the third still counts.
      bad(1'b0); bad(1'b0); bad(1'b0);
      chk("t3_cnt", cnt_a, 16'd4);
      chk("t3_state", 16'(st_a), 16'd0);
      chk("t3_unlocked", 16'(locked_a), 16'd0);

      // 4: zero words never seed; a zero after a VERIFY mismatch returns to SEARCH.
      for (int i = 0; i < 3; i++) step(1'b1, 15'h0000, 1'b0);
      step(1'b1, 15'h1234, 1'b0);
      step(1'b1, 15'h5555, 1'b0);
      chk("t4_reseed", 16'(st_a), 16'd1);
      step(1'b1, 15'h0000, 1'b0);
      chk("t4_search", 16'(st_a), 16'd0);

      // 5: lock with gapped valids, then async reset between edges.
      step(1'b1, 15'h0ace, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, m_exp, 1'b0);
         step(1'b0, 15'h7fff, 1'b0);
      end
      chk("t5_locked", 16'(locked_a), 16'd1);
      @(negedge clk);
      din_valid = 1'b1; din = m_exp;
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      din_valid = 1'b0;
      rst = 1'b1;

      // 6: saturation in the 4-bit instance and clear-vs-error priority.
      step(1'b1, 15'h3c3c, 1'b0);
      good(5);
      for (int i = 0; i < 10; i++) begin
         bad(1'b0); bad(1'b0); good(1);
      end
      chk("t6_sat4", 16'(cnt_b), 16'h000f);
      chk("t6_cnt16", cnt_a, 16'd20);
      bad(1'b1);
      chk("t6_clr_cnt", cnt_a, 16'd0);
      chk("t6_clr_pulse", 16'(pulse_a), 16'd1);
      good(2);
      step(1'b0, 15'h0000, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
